seg7_scan_mux: RTL and testbench
================================

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV_BITS, default 12, meaning width of the scan prescaler; one digit step per 2^SCAN_DIV_BITS clocks.
REQ-003 SHALL have parameter PWM_BITS, default 3, meaning brightness resolution.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, meaning that 1 inverts o_seg, o_dp and o_an, and 0 leaves them active-high.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic is on posedge i_clk.
REQ-006 SHALL have port i_reset, input, 1, the reset, which is synchronous and active-high.
REQ-007 SHALL have port i_value, input, 4*NUM_DIGITS, one nibble per digit; nibble k is digit k, and digit 0 is least significant.
REQ-008 SHALL have port i_dp, input, NUM_DIGITS, decimal point per digit.
REQ-009 SHALL have port i_load, input, 1, single-cycle strobe that captures i_value, i_dp and i_hex.
REQ-010 SHALL have port i_hex, input, 1, where 1 selects hex glyphs and 0 selects decimal.
REQ-011 SHALL have port i_lzb, input, 1, live leading-zero blanking enable.
REQ-012 SHALL have port i_bright, input, PWM_BITS, live brightness.
REQ-013 SHALL have port o_seg, output, 7, segments with bit0=a through bit6=g.
REQ-014 SHALL have port o_dp, output, 1, decimal point segment.
REQ-015 SHALL have port o_an, output, NUM_DIGITS, digit enables; at most one is active at a time.
REQ-016 SHALL have port o_frame, output, 1, one-clock pulse when digit index wraps to 0.

Function
REQ-017 SHALL treat prescaler tick as prescaler all-ones; prescaler increments every clock and wraps modulo 2^SCAN_DIV_BITS.
REQ-018 SHALL advance digit index by 1 on each tick, wrapping NUM_DIGITS-1 -> 0; the wrap clock also asserts o_frame for one cycle.
REQ-019 SHALL double-buffer the display: i_load writes the shadow registers and sets a pending flag; the display register copies shadow and clears pending only on the wrap clock (no mid-frame tearing).
REQ-020 SHALL let the latest i_load win when several loads occur within one frame; if i_load coincides with the wrap clock, the new data goes to shadow and is applied at the next wrap.
REQ-021 SHALL decode digit values 0-9 to standard glyphs; in hex mode 10-15 SHALL be the glyphs A b C d E F; in decimal mode 10-15 SHALL be blank (all segments off).
REQ-022 SHALL, when i_lzb=1, blank digit k (k>=1) if it and every more significant digit in the display register are zero; digit 0 is never zero-blanked, and o_dp is unaffected by blanking.
REQ-023 SHALL run a free-running PWM_BITS counter; segments and dp are lit only when pwm counter <= i_bright, so i_bright all-ones means always lit and 0 means 1/2^PWM_BITS duty.
REQ-024 SHALL register o_seg, o_dp, o_an and o_frame; outputs reflect the digit index with exactly 1 clock latency.
REQ-025 SHALL drive o_an inactive for one clock after each digit index change (ghosting guard) before enabling the new digit.
REQ-026 SHALL apply ACTIVE_LOW inversion only at the output registers; internal logic is active-high.

Reset
REQ-027 SHALL, on i_reset=1 at a clock edge, clear the prescaler, digit index, pwm counter, shadow, display register and pending flag to 0.
REQ-028 SHALL drive o_seg, o_dp and o_an to their inactive level (all 1 when ACTIVE_LOW=1) and o_frame to 0 on the clock after reset.
REQ-029 SHALL give i_reset priority over i_load and tick in the same cycle; reset mid-frame discards pending data.

Verification (NUM_DIGITS=4, SCAN_DIV_BITS=2, PWM_BITS=3, ACTIVE_LOW=0, i_bright=7)
REQ-030 SHALL show that loading i_value=16'h1234 with i_hex=0 and i_lzb=0 produces, after the next o_frame, o_an=0001 with glyph 4 (7'h66), then 0010 with 3 (7'h4F), 0100 with 2 (7'h5B) and 1000 with 1 (7'h06), each digit spaced 4 clocks apart.
REQ-031 SHALL show that i_value=16'h00A0 in decimal mode gives digit 1 blank, and in hex mode gives digit 1 = 7'h77 (A).
REQ-032 SHALL show that i_value=16'h0005 with i_lzb=1 blanks digits 3..1 and shows digit 0 = 7'h6D; i_value=16'h0000 with i_lzb=1 shows only digit 0 = 7'h3F.
REQ-033 SHALL show that two i_load pulses mid-frame (16'h1111 then 16'h2222) result in only 2222 being displayed after the wrap, with no frame ever mixing values.
REQ-034 SHALL show that i_bright=0 lights segments exactly 1 clock in 8, and i_bright=3 lights them 4 clocks in 8.
REQ-035 SHALL show that asserting i_reset mid-frame with a load pending leaves all outputs inactive the next clock, digit index 0, and the pending data never displayed.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment display driver: scan prescaler, digit rotation, double-buffered
// display data, hex/decimal glyph decode, leading-zero blanking and PWM brightness.
module seg7_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_BITS = 12,
    parameter int PWM_BITS      = 3,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    input  logic                    i_hex,
    input  logic                    i_lzb,
    input  logic [PWM_BITS-1:0]     i_bright,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

    logic [SCAN_DIV_BITS-1:0] prescaler;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [IDX_W-1:0]         idx;
    logic                     idx_moved;

    logic [4*NUM_DIGITS-1:0]  shadow_value;
    logic [NUM_DIGITS-1:0]    shadow_dp;
    logic                     shadow_hex;
    logic                     pending;

    logic [4*NUM_DIGITS-1:0]  disp_value;
    logic [NUM_DIGITS-1:0]    disp_dp;
    logic                     disp_hex;

    logic                     tick;
    logic                     wrap;
    logic                     lit;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     upper_zero;
    logic                     lz_blank;
    logic [6:0]               glyph;
    logic [NUM_DIGITS-1:0]    an_next;

    assign tick = &prescaler;
    assign wrap = tick && (idx == LAST_IDX);
    assign lit  = (pwm_cnt <= i_bright);

    // Walk from the most significant digit down so upper_zero covers digit k and everything above it.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        an_next    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_value[4*k +: 4] == 4'h0);
            an_next[k] = (idx == IDX_W'(k));
            if (idx == IDX_W'(k)) begin
                cur_nib  = disp_value[4*k +: 4];
                cur_dp   = disp_dp[k];
                lz_blank = upper_zero && (k != 0);
            end
        end
    end

    always_comb begin
        glyph = 7'h00;
        case (cur_nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
        if (!disp_hex && (cur_nib > 4'd9)) glyph = 7'h00;
        if (i_lzb && lz_blank) glyph = 7'h00;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            idx          <= '0;
            idx_moved    <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_hex   <= 1'b0;
            pending      <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_hex     <= 1'b0;
            o_seg        <= SEG_OFF;
            o_dp         <= ACTIVE_LOW;
            o_an         <= AN_OFF;
            o_frame      <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            idx_moved <= tick;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;

            // A load on the wrap clock lands in shadow and stays pending for the next frame.
            if (wrap && pending) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_hex   <= shadow_hex;
            end
            if (i_load) begin
                shadow_value <= i_value;
                shadow_dp    <= i_dp;
                shadow_hex   <= i_hex;
                pending      <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end

            o_seg   <= (lit ? glyph : 7'h00) ^ SEG_OFF;
            o_dp    <= (lit && cur_dp) ^ ACTIVE_LOW;
            o_an    <= (idx_moved ? '0 : an_next) ^ AN_OFF;
            o_frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Lockstep bench for seg7_scan_mux: a cycle-count based reference predicts every output each clock,
// plus directed checks of scan order, spacing and brightness duty.
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        hex;
    logic        lzb;
    logic [2:0]  bright;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS(4), .SCAN_DIV_BITS(2), .PWM_BITS(3), .ACTIVE_LOW(1'b0)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_value(value), .i_dp(dp), .i_load(load),
        .i_hex(hex), .i_lzb(lzb), .i_bright(bright),
        .o_seg(seg), .o_dp(seg_dp), .o_an(an), .o_frame(frame)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: clocks since reset plus the shadow/display contents.
    int          c = 0;
    logic [15:0] sh_v, dv;
    logic [3:0]  sh_dp, d_dp;
    logic        sh_hex, d_hex, pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;
    logic [3:0]  e_an;

    function automatic logic [6:0] exp_glyph(int k);
        logic [3:0] n;
        n = dv[4*k +: 4];
        if (lzb && k >= 1 && (dv >> (4*k)) == 16'h0) return 7'h00;
        if (!d_hex && n > 4'd9) return 7'h00;
        return glyph_tbl[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int  k;
        bit  lit, wrp;
        if (rst) begin
            e_seg = 0; e_dp = 0; e_an = 0; e_frame = 0;
            c = 0; sh_v = 0; dv = 0; sh_dp = 0; d_dp = 0; sh_hex = 0; d_hex = 0; pend = 0;
        end else begin
            k       = (c / 4) % 4;
            lit     = (c % 8) <= int'(bright);
            wrp     = (c % 16) == 15;
            e_an    = (c % 4 == 0 && c > 0) ? 4'h0 : 4'(1 << k);
            e_seg   = lit ? exp_glyph(k) : 7'h00;
            e_dp    = lit && d_dp[k];
            e_frame = wrp;
            if (wrp && pend) begin dv = sh_v; d_dp = sh_dp; d_hex = sh_hex; end
            if (load) begin sh_v = value; sh_dp = dp; sh_hex = hex; pend = 1; end
            else if (wrp) pend = 0;
            c++;
        end
        @(posedge clk);
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(seg_dp), 32'(e_dp));
        check("an", 32'(an), 32'(e_an));
        check("frame", 32'(frame), 32'(e_frame));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic h);
        value = v; dp = d; hex = h; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    logic [6:0] req30_glyph [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    int  found, last_t, now_t, lit_cnt;

    initial begin
        rst = 1'b1; value = '0; dp = '0; load = 1'b0; hex = 1'b0; lzb = 1'b0; bright = 3'd7;
        #1;
        run(2);
        check("reset_an", 32'(an), 32'h0);
        check("reset_seg", 32'(seg), 32'h0);
        rst = 1'b0;
        run(5);

        // Scan order and spacing for 1234 after the next frame pulse.
        do_load(16'h1234, 4'h0, 1'b0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin cycle(); found = int'(frame); end
        check("frame_seen", 32'(found), 32'h1);
        last_t = 0;
        for (int d = 0; d < 4; d++) begin
            found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                cycle();
                found = int'(an == 4'(1 << d));
            end
            now_t = c;
            check("scan_found", 32'(found), 32'h1);
            check("scan_glyph", 32'(seg), 32'(req30_glyph[d]));
            if (d > 0) check("scan_spacing", 32'(now_t - last_t), 32'd4);
            last_t = now_t;
        end

        // Decimal vs hex for 00A0, then leading-zero blanking.
        do_load(16'h00A0, 4'h0, 1'b0); run(40);
        do_load(16'h00A0, 4'h0, 1'b1); run(40);
        lzb = 1'b1;
        do_load(16'h0005, 4'h0, 1'b0); run(40);
        do_load(16'h0000, 4'h5, 1'b0); run(40);
        lzb = 1'b0;

        // Two loads inside one frame: only the second may appear.
        run(3);
        do_load(16'h1111, 4'h0, 1'b0); run(2);
        do_load(16'h2222, 4'h0, 1'b0); run(40);

        // Brightness duty over 8 consecutive clocks.
        do_load(16'h8888, 4'hF, 1'b0); run(40);
        bright = 3'd0; cycle();
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin cycle(); lit_cnt += int'(seg != 7'h00); end
        check("duty_b0", 32'(lit_cnt), 32'd1);
        bright = 3'd3; cycle();
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin cycle(); lit_cnt += int'(seg != 7'h00); end
        check("duty_b3", 32'(lit_cnt), 32'd4);
        bright = 3'd7;

        // Reset mid-frame with a load pending.
        run(5);
        do_load(16'h9876, 4'hA, 1'b1); run(2);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_mid_an", 32'(an), 32'h0);
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 11) == 0);
            if (load) begin
                value = 16'($urandom); dp = 4'($urandom); hex = 1'($urandom);
            end
            if ($urandom_range(0, 49) == 0) bright = 3'($urandom);
            if ($urandom_range(0, 99) == 0) lzb = 1'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            cycle();
        end
        load = 1'b0; rst = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
